// File: rtl/usart_tx_sched_pkg.sv
// Shared definitions for the USART transmit scheduler: FSM encoding,
// HMI terminator defaults, timeout defaults and a one-hot decode helper.
package usart_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TSEND = 3'd4,
    ST_TWAIT = 3'd5
  } state_t;

  localparam logic [7:0] HMI_TERM_BYTE = 8'hFF;
  localparam int         HMI_TERM_LEN  = 3;
  localparam int         DEF_TO_CYC    = 500000;
  localparam int         DEF_TOW       = 20;

  // One-hot (up to four requesters) to binary index; zero vector maps to 0.
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/usart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping around. The pointer register lives in the parent.
module usart_tx_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o
);

  logic [2*NREQ-1:0] dbl_s;
  logic [2*NREQ-1:0] rot_dbl_s;
  logic [2*NREQ-1:0] back_dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [NREQ-1:0]   low_s;

  // Rotate so the pointer source is bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_s      = {req_i, req_i};
    rot_dbl_s  = dbl_s >> ptr_i;
    rot_s      = rot_dbl_s[NREQ-1:0];
    low_s      = rot_s & (~rot_s + {{(NREQ-1){1'b0}}, 1'b1});
    back_dbl_s = {low_s, low_s} << ptr_i;
    pick_o     = back_dbl_s[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/usart_tx_sched.sv
// usart_tx_sched: shares one USART byte send engine between NREQ frame
// sources. Round-robin grant held for a whole frame; every frame (including
// a timed-out one) is followed by TERM_LEN copies of TERM_BYTE.
module usart_tx_sched
  import usart_tx_sched_pkg::*;
#(
  parameter int            NREQ      = 2,
  parameter int            DW        = 8,
  parameter int            TERM_LEN  = HMI_TERM_LEN,
  parameter logic [DW-1:0] TERM_BYTE = DW'(HMI_TERM_BYTE),
  parameter int            TO_CYC    = DEF_TO_CYC,
  parameter int            TOW       = DEF_TOW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [DW-1:0]     tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              frame_abort
);

  localparam int PW  = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int TCW = (TERM_LEN > 1) ? $clog2(TERM_LEN + 1) : 1;
  localparam logic [TCW-1:0] TERM_LEN_C = TCW'(TERM_LEN);
  localparam logic [TCW-1:0] TCNT_ONE   = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [TOW-1:0] TO_LAST    = TOW'(TO_CYC - 1);
  localparam logic [TOW-1:0] CNT_ONE    = {{(TOW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]  PTR_MAX    = PW'(NREQ - 1);
  localparam logic [PW-1:0]  PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TOW-1:0]    cnt_q, cnt_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic              last_q, last_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              abort_q, abort_d;

  logic [NREQ-1:0]   pick_s;
  logic [3:0]        pick4_s;
  logic [PW-1:0]     win_idx_s;
  logic [PW-1:0]     ptr_next_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DW-1:0]     sel_data_s;

  usart_tx_sched_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick_s)
  );

  // Winner index and the pointer value one past it (mod NREQ).
  always_comb begin
    pick4_s                = 4'b0000;
    pick4_s[NREQ-1:0]      = pick_s;
    win_idx_s              = PW'(oh2idx(pick4_s));
    if (win_idx_s == PTR_MAX) begin
      ptr_next_s = {PW{1'b0}};
    end else begin
      ptr_next_s = win_idx_s + PTR_ONE;
    end
  end

  // Select the byte, valid and last of the granted source.
  always_comb begin
    sel_valid_s = |(req_valid & grant_q);
    sel_last_s  = |(req_last & grant_q);
    sel_data_s  = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        sel_data_s = sel_data_s | req_data[i*DW +: DW];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state logic: arbitration, byte fetch with timeout, send and terminator.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick_s;
          ptr_d   = ptr_next_s;
          cnt_d   = {TOW{1'b0}};
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (sel_valid_s) begin
          tx_data_d = sel_data_s;
          last_d    = sel_last_s;
          cnt_d     = {TOW{1'b0}};
          state_d   = ST_SEND;
        end else if (cnt_q == TO_LAST) begin
          abort_d = 1'b1;
          cnt_d   = {TOW{1'b0}};
          tcnt_d  = {TCW{1'b0}};
          if (TERM_LEN == 0) begin
            grant_d = {NREQ{1'b0}};
            state_d = ST_IDLE;
          end else begin
            tx_data_d = TERM_BYTE;
            state_d   = ST_TSEND;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (!last_q) begin
            cnt_d   = {TOW{1'b0}};
            state_d = ST_FETCH;
          end else if (TERM_LEN == 0) begin
            grant_d = {NREQ{1'b0}};
            state_d = ST_IDLE;
          end else begin
            tcnt_d    = {TCW{1'b0}};
            tx_data_d = TERM_BYTE;
            state_d   = ST_TSEND;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_TSEND: begin
        state_d = ST_TWAIT;
      end
      ST_TWAIT: begin
        if (tx_done) begin
          if ((tcnt_q + TCNT_ONE) == TERM_LEN_C) begin
            grant_d = {NREQ{1'b0}};
            state_d = ST_IDLE;
          end else begin
            tcnt_d  = tcnt_q + TCNT_ONE;
            state_d = ST_TSEND;
          end
        end else begin
          state_d = ST_TWAIT;
        end
      end
      default: begin
        grant_d = {NREQ{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst drops everything back to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= {NREQ{1'b0}};
      ptr_q     <= {PW{1'b0}};
      cnt_q     <= {TOW{1'b0}};
      tcnt_q    <= {TCW{1'b0}};
      last_q    <= 1'b0;
      tx_data_q <= {DW{1'b0}};
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      abort_q   <= abort_d;
    end
  end

  assign req_ready   = (state_q == ST_FETCH) ? grant_q : {NREQ{1'b0}};
  assign tx_start    = (state_q == ST_SEND) || (state_q == ST_TSEND);
  assign busy        = (state_q != ST_IDLE);
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_usart_tx_sched.sv
// Scoreboard bench for usart_tx_sched: a send-engine model answers each
// tx_start with tx_done 20 cycles later; expected bytes/grants are queued
// when a frame is scheduled and popped on every tx_start.
module tb_usart_tx_sched;

  localparam int NREQ = 2;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_done;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              frame_abort;
  logic              eng_done;
  logic              spur_done;

  logic [NREQ-1:0]   r0_valid;
  logic [NREQ*DW-1:0] r0_data;
  logic [NREQ-1:0]   r0_last;
  logic [NREQ-1:0]   r0_ready;
  logic [DW-1:0]     tx0_data;
  logic              tx0_start;
  logic              tx0_done;
  logic [NREQ-1:0]   grant0;
  logic              busy0;
  logic              abort0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_abort = 0;
  int abort_gap = -1;
  int last_done_cyc = 0;
  int start_cyc[$];
  int n2_start = 0;
  int n2_done = 0;
  logic [7:0] d2_first = 8'h00;
  logic [9:0] sb[$];

  assign tx_done = eng_done | spur_done;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  usart_tx_sched #(
    .NREQ(NREQ), .DW(DW), .TERM_LEN(3), .TERM_BYTE(8'hFF), .TO_CYC(100), .TOW(20)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_done(tx_done), .grant(grant), .busy(busy),
    .frame_abort(frame_abort)
  );

  usart_tx_sched #(
    .NREQ(NREQ), .DW(DW), .TERM_LEN(0), .TERM_BYTE(8'hFF), .TO_CYC(100), .TOW(20)
  ) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_data(r0_data),
    .req_last(r0_last), .req_ready(r0_ready), .tx_data(tx0_data),
    .tx_start(tx0_start), .tx_done(tx0_done), .grant(grant0), .busy(busy0),
    .frame_abort(abort0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int src, input logic [7:0] d);
    logic [1:0] g;
    g = 2'b01 << src;
    sb.push_back({g, d});
  endtask

  task automatic push_term(input int src);
    for (int i = 0; i < 3; i++) push_exp(src, 8'hFF);
  endtask

  // Called at a negedge; holds the byte until accepted, returns at a negedge.
  task automatic put_byte(input int src, input logic [7:0] d, input logic lst);
    int t;
    req_valid[src] = 1'b1;
    req_data[src*DW +: DW] = d;
    req_last[src] = lst;
    t = 0;
    while (!req_ready[src] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val("ready_timeout", 32'(t < 2000), 32'd1);
    @(negedge clk);
    req_valid[src] = 1'b0;
    req_last[src] = 1'b0;
  endtask

  task automatic send_frame(input int src, input int n, input logic [7:0] b0, input logic [7:0] b1);
    if (n == 1) begin
      put_byte(src, b0, 1'b1);
    end else begin
      put_byte(src, b0, 1'b0);
      put_byte(src, b1, 1'b1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val("idle_timeout", 32'(t < 3000), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  // Send engine model for the main instance.
  initial begin
    int ecnt;
    ecnt = 0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst) begin
        ecnt = 0;
      end else if (ecnt == 1) begin
        eng_done = 1'b1;
        last_done_cyc = cyc;
        ecnt = 0;
      end else if (ecnt > 1) begin
        ecnt = ecnt - 1;
      end else if (tx_start) begin
        ecnt = 20;
      end
    end
  end

  // Send engine model for the no-terminator instance.
  initial begin
    int ecnt;
    ecnt = 0;
    tx0_done = 1'b0;
    forever begin
      @(negedge clk);
      tx0_done = 1'b0;
      if (rst) begin
        ecnt = 0;
      end else if (ecnt == 1) begin
        tx0_done = 1'b1;
        n2_done++;
        ecnt = 0;
      end else if (ecnt > 1) begin
        ecnt = ecnt - 1;
      end else if (tx0_start) begin
        ecnt = 20;
      end
    end
  end

  // Scoreboard monitor for the main instance.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start) begin
          n_start++;
          start_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            check_val("start_unexpected", 32'(tx_start), 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("tx_data", 32'(tx_data), 32'(e[7:0]));
            check_val("grant_at_start", 32'(grant), 32'(e[9:8]));
          end
        end
        if (frame_abort) begin
          n_abort++;
          abort_gap = cyc - last_done_cyc - 1;
        end
      end
    end
  end

  // Start monitor for the no-terminator instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx0_start) begin
        if (n2_start == 0) d2_first = tx0_data;
        n2_start++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int t;
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    r0_valid = '0; r0_data = '0; r0_last = '0;
    spur_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_abort", 32'(frame_abort), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1) three-byte frame from source 0
    base = n_start;
    start_cyc.delete();
    push_exp(0, 8'h70); push_exp(0, 8'h61); push_exp(0, 8'h67); push_term(0);
    t0 = cyc;
    put_byte(0, 8'h70, 1'b0);
    put_byte(0, 8'h61, 1'b0);
    put_byte(0, 8'h67, 1'b1);
    wait_idle();
    check_val("t1_latency", 32'(start_cyc[0] - t0), 32'd2);
    check_val("t1_starts", 32'(n_start - base), 32'd6);
    check_val("t1_busy", 32'(busy), 32'd0);
    check_val("t1_grant", 32'(grant), 32'd0);

    // 2) simultaneous requests from reset, then a second tie
    do_reset();
    push_exp(0, 8'hA0); push_exp(0, 8'hA1); push_term(0);
    push_exp(1, 8'hB0); push_exp(1, 8'hB1); push_term(1);
    fork
      send_frame(0, 2, 8'hA0, 8'hA1);
      send_frame(1, 2, 8'hB0, 8'hB1);
    join
    wait_idle();
    push_exp(0, 8'hC0); push_term(0);
    push_exp(1, 8'hD0); push_term(1);
    fork
      send_frame(0, 1, 8'hC0, 8'h00);
      send_frame(1, 1, 8'hD0, 8'h00);
    join
    wait_idle();

    // 3) timeout after one byte
    base = n_abort;
    push_exp(0, 8'h33); push_term(0);
    put_byte(0, 8'h33, 1'b0);
    wait_idle();
    check_val("t3_abort_cnt", 32'(n_abort - base), 32'd1);
    check_val("t3_abort_gap", 32'(abort_gap), 32'd100);
    check_val("t3_grant", 32'(grant), 32'd0);

    // 4) spurious tx_done in IDLE and FETCH
    base = n_start;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    check_val("t4_idle_busy", 32'(busy), 32'd0);
    check_val("t4_idle_starts", 32'(n_start - base), 32'd0);
    push_exp(0, 8'h11); push_exp(0, 8'h22); push_term(0);
    put_byte(0, 8'h11, 1'b0);
    t = 0;
    while (!req_ready[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check_val("t4_fetch_ready", 32'(req_ready), 32'd1);
    check_val("t4_fetch_busy", 32'(busy), 32'd1);
    check_val("t4_fetch_starts", 32'(n_start - base), 32'd1);
    put_byte(0, 8'h22, 1'b1);
    wait_idle();
    check_val("t4_total_starts", 32'(n_start - base), 32'd5);

    // 5) reset during the second terminator wait
    base = n_start;
    push_exp(0, 8'h55); push_term(0);
    put_byte(0, 8'h55, 1'b1);
    t = 0;
    while (n_start < base + 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t5_tx_data", 32'(tx_data), 32'd0);
    check_val("t5_tx_start", 32'(tx_start), 32'd0);
    check_val("t5_grant", 32'(grant), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_ready", 32'(req_ready), 32'd0);
    check_val("t5_sb_left", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(1, 8'h5A); push_term(1);
    put_byte(1, 8'h5A, 1'b1);
    wait_idle();
    check_val("t5_after_grant", 32'(grant), 32'd0);

    // 6) no-terminator build, single byte frame
    r0_valid[0] = 1'b1;
    r0_data[7:0] = 8'h41;
    r0_last[0] = 1'b1;
    t = 0;
    while (!r0_ready[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    r0_valid[0] = 1'b0;
    r0_last[0] = 1'b0;
    t = 0;
    while (n2_done == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_val("t6_busy_after_done", 32'(busy0), 32'd0);
    check_val("t6_grant", 32'(grant0), 32'd0);
    repeat (30) @(negedge clk);
    check_val("t6_starts", 32'(n2_start), 32'd1);
    check_val("t6_data", 32'(d2_first), 32'h41);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
